// File: rtl/uart_pkg.sv
// Shared UART definitions: frame length, FSM encoding, parity and frame assembly.
package uart_pkg;

  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_SHIFT  = 2'd2
  } uart_state_e;

  // ohel=0 gives even parity (^data), ohel=1 gives odd parity (~^data).
  function automatic logic parity(input logic [7:0] data, input logic eight, input logic ohel);
    logic p;
    p = eight ? (^data) : (^data[6:0]);
    return p ^ ohel;
  endfunction

  // Frame in transmit order, bit0 first: start, data, optional parity, stop fill.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data, input logic eight,
                                                        input logic pen, input logic ohel);
    logic [FRAME_BITS-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    if (eight) begin
      f[8:1] = data;
      if (pen) f[9] = parity(data, eight, ohel);
    end else begin
      f[7:1] = data[6:0];
      if (pen) f[8] = parity(data, eight, ohel);
    end
    return f;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-time divisor: counts 0..K-1 while enabled, pulsing BTU on the last count.
module tx_bit_timer #(
  parameter int K_W = 19
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic [K_W-1:0] K,
  output logic           BTU
);

  logic [K_W-1:0] cnt_q;
  logic [K_W-1:0] last;

  // K of 0 or 1 both mean one clock per bit; equality compare so a mid-frame K change
  // simply lands on whichever count matches next.
  assign last = (K <= K_W'(1)) ? '0 : K - K_W'(1);
  assign BTU  = !clr && (cnt_q == last);

  always_ff @(posedge clk) begin
    if (rst || clr || BTU) cnt_q <= '0;
    else                   cnt_q <= cnt_q + K_W'(1);
  end

endmodule

// File: rtl/tx_datapath.sv
// UART transmitter: latches a byte on LOAD and shifts an 11-bit frame out LSB-first on TX.
module tx_datapath
  import uart_pkg::*;
#(
  parameter int K_W = 19
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           LOAD,
  input  logic [7:0]     OUT_PORT,
  input  logic           EIGHT,
  input  logic           PEN,
  input  logic           OHEL,
  input  logic [K_W-1:0] K,
  output logic           TX,
  output logic           TXRDY
);

  uart_state_e           state_q, state_d;
  logic [7:0]            data_q;
  logic                  eight_q, pen_q, ohel_q;
  logic [FRAME_BITS-1:0] sr_q;
  logic [3:0]            bitcnt_q;
  logic                  btu, done;
  logic                  latch_en, sr_load, tmr_clr, rdy;

  tx_bit_timer #(.K_W(K_W)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .K   (K),
    .BTU (btu)
  );

  assign done = btu && (bitcnt_q == 4'(FRAME_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (LOAD) state_d = ST_LOADED;
      ST_LOADED: state_d = ST_SHIFT;
      ST_SHIFT:  if (done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Timer is held clear outside SHIFT so every frame starts from a full bit time.
  always_comb begin
    latch_en = 1'b0;
    sr_load  = 1'b0;
    tmr_clr  = 1'b1;
    rdy      = 1'b0;
    case (state_q)
      ST_IDLE:   begin rdy = 1'b1; latch_en = LOAD; end
      ST_LOADED: sr_load = 1'b1;
      ST_SHIFT:  tmr_clr = 1'b0;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      eight_q  <= 1'b0;
      pen_q    <= 1'b0;
      ohel_q   <= 1'b0;
      sr_q     <= '1;
      bitcnt_q <= '0;
    end else begin
      if (latch_en) begin
        data_q  <= OUT_PORT;
        eight_q <= EIGHT;
        pen_q   <= PEN;
        ohel_q  <= OHEL;
      end
      if (sr_load) begin
        sr_q     <= build_frame(data_q, eight_q, pen_q, ohel_q);
        bitcnt_q <= '0;
      end else if (btu) begin
        sr_q     <= {1'b1, sr_q[FRAME_BITS-1:1]};
        bitcnt_q <= done ? 4'd0 : bitcnt_q + 4'd1;
      end
    end
  end

  assign TX    = sr_q[0];
  assign TXRDY = rdy;

endmodule

// File: tb/tb_tx_datapath.sv
// Bench for tx_datapath: directed and random frames against a bit-list frame model.
module tb_tx_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        LOAD = 1'b0;
  logic [7:0]  OUT_PORT = '0;
  logic        EIGHT = 1'b0, PEN = 1'b0, OHEL = 1'b0;
  logic [18:0] K = 19'd4;
  logic        TX, TXRDY;

  int total = 0;
  int bad   = 0;

  tx_datapath #(.K_W(19)) dut (
    .clk(clk), .rst(rst), .LOAD(LOAD), .OUT_PORT(OUT_PORT), .EIGHT(EIGHT),
    .PEN(PEN), .OHEL(OHEL), .K(K), .TX(TX), .TXRDY(TXRDY)
  );

  always #5 clk = ~clk;

  // Frame as a list of line levels: start 0, data bits, parity from a ones count, then 1s.
  function automatic logic [10:0] exp_frame(input logic [7:0] d, input logic e, input logic p,
                                            input logic o);
    logic [10:0] f;
    int nd, ones;
    nd = e ? 8 : 7;
    ones = 0;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < nd; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    if (p) f[nd+1] = ((ones % 2) == 1) ^ o;
    return f;
  endfunction

  // Starts at a negedge with TXRDY=1, ends at the negedge of the first TXRDY=1 cycle after.
  task automatic run_frame(input logic [7:0] d, input logic e, input logic p, input logic o,
                           input int k, input bit disturb);
    logic [10:0] f;
    int ke;
    f  = exp_frame(d, e, p, o);
    ke = (k <= 1) ? 1 : k;
    OUT_PORT = d; EIGHT = e; PEN = p; OHEL = o; K = 19'(k); LOAD = 1'b1;
    @(negedge clk);
    LOAD = 1'b0;
    total++;
    if (TX !== 1'b1 || TXRDY !== 1'b0) begin
      bad++;
      $display("FAIL load_ack: TX=%b TXRDY=%b expected TX=1 TXRDY=0", TX, TXRDY);
    end
    for (int j = 0; j < 11 * ke; j++) begin
      @(negedge clk);
      total++;
      if (TX !== f[j/ke] || TXRDY !== 1'b0) begin
        bad++;
        $display("FAIL frame_bit d=%h k=%0d slot=%0d: TX=%b TXRDY=%b expected TX=%b TXRDY=0",
                 d, k, j / ke, TX, TXRDY, f[j/ke]);
      end
      if (disturb && j == 5) begin
        LOAD = 1'b1; OUT_PORT = 8'hFF; EIGHT = ~e; PEN = ~p; OHEL = ~o;
      end
      if (disturb && j == 6) LOAD = 1'b0;
    end
    @(negedge clk);
    total++;
    if (TX !== 1'b1 || TXRDY !== 1'b1) begin
      bad++;
      $display("FAIL frame_end d=%h k=%0d: TX=%b TXRDY=%b expected TX=1 TXRDY=1", d, k, TX, TXRDY);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total++;
      if (TX !== 1'b1 || TXRDY !== 1'b1) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d: TX=%b TXRDY=%b expected TX=1 TXRDY=1", i, TX, TXRDY);
      end
    end
  endtask

  task automatic test_directed;
    run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 4, 1'b0);
    repeat (3) @(negedge clk);
    run_frame(8'hA5, 1'b1, 1'b1, 1'b1, 4, 1'b0);
    repeat (3) @(negedge clk);
    run_frame(8'hC3, 1'b0, 1'b1, 1'b1, 4, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_midframe;
    run_frame(8'h55, 1'b0, 1'b0, 1'b0, 4, 1'b1);
    // The dropped LOAD must not leave a queued frame behind.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (TX !== 1'b1 || TXRDY !== 1'b1) begin
        bad++;
        $display("FAIL no_queue cyc=%0d: TX=%b TXRDY=%b expected TX=1 TXRDY=1", i, TX, TXRDY);
      end
    end
  endtask

  task automatic test_back_to_back;
    run_frame(8'h3A, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    run_frame(8'hC5, 1'b1, 1'b1, 1'b1, 1, 1'b0);
    run_frame(8'h0F, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    run_frame(8'h81, 1'b1, 1'b1, 1'b0, 3, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random;
    for (int n = 0; n < 25; n++) begin
      run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 5)), 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_reset_midframe;
    OUT_PORT = 8'h3C; EIGHT = 1'b1; PEN = 1'b1; OHEL = 1'b0; K = 19'd4; LOAD = 1'b1;
    @(negedge clk);
    LOAD = 1'b0;
    // Run into the middle of data bit 3 (frame slot 4).
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (TX !== 1'b1 || TXRDY !== 1'b1) begin
      bad++;
      $display("FAIL reset_abort: TX=%b TXRDY=%b expected TX=1 TXRDY=1", TX, TXRDY);
    end
    repeat (2) @(negedge clk);
    run_frame(8'h96, 1'b1, 1'b1, 1'b1, 4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_midframe();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
